// File: rtl/mext_pkg.sv
// rtl/mext_pkg.sv - shared types and constants for the RV32M execute-stage sequencer
package mext_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mext_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_FIXUP  = 3'd3,
        ST_DONE   = 3'd4
    } mext_state_e;

    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

    function automatic logic is_div_op(input mext_op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/mext_if.sv
// rtl/mext_if.sv - start/done handshake between the sequencer and the iterative mul/div core
interface mext_if #(
    parameter int XLEN = 32
);
    logic              core_start;
    logic              core_abort;
    logic              core_is_div;
    logic [XLEN-1:0]   core_a;
    logic [XLEN-1:0]   core_b;
    logic              core_done;
    logic [2*XLEN-1:0] core_prod;
    logic [XLEN-1:0]   core_quot;
    logic [XLEN-1:0]   core_rem;

    modport master (
        output core_start, core_abort, core_is_div, core_a, core_b,
        input  core_done, core_prod, core_quot, core_rem
    );

    modport slave (
        input  core_start, core_abort, core_is_div, core_a, core_b,
        output core_done, core_prod, core_quot, core_rem
    );
endinterface

// File: rtl/mext_sign_fixup.sv
// rtl/mext_sign_fixup.sv - operand magnitudes, special-case detection and result sign fix-up
module mext_sign_fixup
    import mext_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit ZERO_BYPASS = 1'b1
) (
    input  mext_op_e          op,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [XLEN-1:0]   mag_a,
    output logic [XLEN-1:0]   mag_b,
    output logic              sign_a,
    output logic              sign_b,
    output logic              special,
    output logic [XLEN-1:0]   special_res,
    input  mext_op_e          fix_op,
    input  logic              fix_sign_a,
    input  logic              fix_sign_b,
    input  logic [2*XLEN-1:0] prod,
    input  logic [XLEN-1:0]   quot,
    input  logic [XLEN-1:0]   rem,
    output logic [XLEN-1:0]   fixed_res
);

    localparam logic [XLEN-1:0] ALL_ONES = '1;
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    logic              a_signed;
    logic              b_signed;
    logic [2*XLEN-1:0] prod_s;

    always_comb begin
        a_signed    = op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        b_signed    = op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
        sign_a      = a_signed & a[XLEN-1];
        sign_b      = b_signed & b[XLEN-1];
        // MIN_NEG negates to itself, which is the correct unsigned magnitude
        mag_a       = sign_a ? -a : a;
        mag_b       = sign_b ? -b : b;
        special     = 1'b0;
        special_res = '0;
        if (is_div_op(op)) begin
            if (b == '0) begin
                special     = 1'b1;
                special_res = op[1] ? a : ALL_ONES;
            end else if (b_signed && a == MIN_NEG && b == ALL_ONES) begin
                special     = 1'b1;
                special_res = op[1] ? '0 : MIN_NEG;
            end
        end else if (ZERO_BYPASS && (a == '0 || b == '0)) begin
            special = 1'b1;
        end
    end

    always_comb begin
        prod_s    = (fix_sign_a ^ fix_sign_b) ? -prod : prod;
        fixed_res = '0;
        if (!fix_op[2]) begin
            fixed_res = (fix_op == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        end else if (!fix_op[1]) begin
            fixed_res = (fix_sign_a ^ fix_sign_b) ? -quot : quot;
        end else begin
            fixed_res = fix_sign_a ? -rem : rem;
        end
    end

endmodule

// File: rtl/mext_sequencer.sv
// rtl/mext_sequencer.sv - EX-stage controller sequencing one RV32M op through the shared mul/div core
module mext_sequencer
    import mext_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit ZERO_BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            flush,
    output logic            stall_o,
    output logic            res_valid,
    output logic [XLEN-1:0] res_o,
    mext_if.master          core
);

    mext_state_e       state, next_state;
    mext_op_e          op_q;
    logic              sign_a_q, sign_b_q, special_q;
    logic [XLEN-1:0]   a_mag_q, b_mag_q, special_res_q, res_q;
    logic [2*XLEN-1:0] prod_q;
    logic [XLEN-1:0]   quot_q, rem_q;

    logic              accept;
    logic [XLEN-1:0]   cap_mag_a, cap_mag_b, cap_special_res, fixed_res;
    logic              cap_sign_a, cap_sign_b, cap_special;

    mext_sign_fixup #(
        .XLEN        (XLEN),
        .ZERO_BYPASS (ZERO_BYPASS)
    ) u_sign_fixup (
        .op          (mext_op_e'(req_op)),
        .a           (req_a),
        .b           (req_b),
        .mag_a       (cap_mag_a),
        .mag_b       (cap_mag_b),
        .sign_a      (cap_sign_a),
        .sign_b      (cap_sign_b),
        .special     (cap_special),
        .special_res (cap_special_res),
        .fix_op      (op_q),
        .fix_sign_a  (sign_a_q),
        .fix_sign_b  (sign_b_q),
        .prod        (prod_q),
        .quot        (quot_q),
        .rem         (rem_q),
        .fixed_res   (fixed_res)
    );

    assign accept           = (state == ST_IDLE) && req_valid && !flush;
    assign res_o            = res_q;
    assign core.core_a      = a_mag_q;
    assign core.core_b      = b_mag_q;
    assign core.core_is_div = is_div_op(op_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state      = state;
        stall_o         = 1'b0;
        res_valid       = 1'b0;
        core.core_start = 1'b0;
        core.core_abort = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    stall_o    = 1'b1;
                    next_state = cap_special ? ST_FIXUP : ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                stall_o = 1'b1;
                if (flush) begin
                    core.core_abort = 1'b1;
                    next_state      = ST_IDLE;
                end else begin
                    core.core_start = 1'b1;
                    next_state      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall_o = 1'b1;
                if (flush) begin
                    core.core_abort = 1'b1;
                    next_state      = ST_IDLE;
                end else if (core.core_done) begin
                    next_state = ST_FIXUP;
                end
            end
            ST_FIXUP: begin
                stall_o    = 1'b1;
                next_state = flush ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                res_valid  = !flush;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q          <= OP_MUL;
            sign_a_q      <= 1'b0;
            sign_b_q      <= 1'b0;
            special_q     <= 1'b0;
            a_mag_q       <= '0;
            b_mag_q       <= '0;
            special_res_q <= '0;
            prod_q        <= '0;
            quot_q        <= '0;
            rem_q         <= '0;
            res_q         <= '0;
        end else begin
            if (accept) begin
                op_q          <= mext_op_e'(req_op);
                sign_a_q      <= cap_sign_a;
                sign_b_q      <= cap_sign_b;
                special_q     <= cap_special;
                a_mag_q       <= cap_mag_a;
                b_mag_q       <= cap_mag_b;
                special_res_q <= cap_special_res;
            end
            if (state == ST_WAIT && core.core_done && !flush) begin
                prod_q <= core.core_prod;
                quot_q <= core.core_quot;
                rem_q  <= core.core_rem;
            end
            if (state == ST_FIXUP && !flush) begin
                res_q <= special_q ? special_res_q : fixed_res;
            end
        end
    end

endmodule

// File: tb/tb_mext_sequencer.sv
// tb/tb_mext_sequencer.sv - directed self-checking bench for mext_sequencer with a stub iterative core
module tb_mext_sequencer;
    import mext_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        flush;
    logic        stall_o;
    logic        res_valid;
    logic [31:0] res_o;

    mext_if #(.XLEN(32)) bus ();

    mext_sequencer #(
        .XLEN        (32),
        .ZERO_BYPASS (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .flush     (flush),
        .stall_o   (stall_o),
        .res_valid (res_valid),
        .res_o     (res_o),
        .core      (bus)
    );

    always #5 clk = ~clk;

    // Stub core: latches magnitudes on start, pulses done core_lat cycles later
    int          core_lat   = 32;
    int          start_cnt  = 0;
    int          abort_cnt  = 0;
    logic        force_done = 1'b0;
    logic [6:0]  cnt;
    logic [31:0] ca, cb;

    always @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            ca  <= '0;
            cb  <= '0;
        end else if (bus.core_abort) begin
            cnt <= '0;
        end else if (bus.core_start) begin
            cnt <= 7'(core_lat);
            ca  <= bus.core_a;
            cb  <= bus.core_b;
        end else if (cnt != 0) begin
            cnt <= cnt - 7'd1;
        end
        if (bus.core_start) start_cnt <= start_cnt + 1;
        if (bus.core_abort) abort_cnt <= abort_cnt + 1;
    end

    assign bus.core_done = (cnt == 7'd1) || force_done;
    assign bus.core_prod = {32'b0, ca} * {32'b0, cb};
    assign bus.core_quot = (cb == 0) ? 32'hFFFF_FFFF : ca / cb;
    assign bus.core_rem  = (cb == 0) ? ca : ca % cb;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Entered just after a rising edge; returns just after the rising edge that ends DONE
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int stl, output int ns);
        int s0;
        s0        = start_cnt;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        lat       = -1;
        stl       = 0;
        res       = '0;
        for (int i = 0; i < 120 && lat < 0; i++) begin
            @(negedge clk);
            if (stall_o) stl++;
            if (res_valid) begin
                lat = i;
                res = res_o;
            end
        end
        ns = start_cnt - s0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    logic [31:0] res;
    int          lat, stl, ns, s0, a0, bad;

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        flush     = 1'b0;
        req_op    = 3'd0;
        req_a     = '0;
        req_b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", stall_o, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res", res_o, 0);
        check("rst_start", bus.core_start, 0);
        check("rst_abort", bus.core_abort, 0);
        check("rst_core_a", bus.core_a, 0);
        check("rst_is_div", bus.core_is_div, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        core_lat = 32;
        do_op(3'd1, 32'hFFFF_FFFE, 32'd3, res, lat, stl, ns);
        check("mulh_res", res, 32'hFFFF_FFFF);
        check("mulh_lat", lat, 35);
        check("mulh_stall", stl, 35);
        check("mulh_starts", ns, 1);
        check("mulh_core_a", ca, 2);
        check("mulh_core_b", cb, 3);
        check("mulh_valid_1cyc", res_valid, 0);

        core_lat = 4;
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, res, lat, stl, ns);
        check("div_res", res, 32'hFFFF_FFFD);
        check("div_lat", lat, 7);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, res, lat, stl, ns);
        check("rem_res", res, 32'hFFFF_FFFF);

        do_op(3'd5, 32'd5, 32'd0, res, lat, stl, ns);
        check("divu0_res", res, DIV_ZERO_Q);
        check("divu0_lat", lat, 2);
        check("divu0_starts", ns, 0);
        do_op(3'd7, 32'h1234, 32'd0, res, lat, stl, ns);
        check("remu0_res", res, 32'h1234);
        check("remu0_lat", lat, 2);

        do_op(3'd4, INT_MIN, 32'hFFFF_FFFF, res, lat, stl, ns);
        check("divovf_res", res, 32'h8000_0000);
        check("divovf_starts", ns, 0);
        do_op(3'd6, INT_MIN, 32'hFFFF_FFFF, res, lat, stl, ns);
        check("removf_res", res, 0);
        check("removf_starts", ns, 0);

        do_op(3'd0, 32'd0, 32'd5, res, lat, stl, ns);
        check("mulzero_res", res, 0);
        check("mulzero_lat", lat, 2);
        check("mulzero_starts", ns, 0);

        // Flush in the fifth WAIT cycle
        core_lat  = 32;
        s0        = start_cnt;
        a0        = abort_cnt;
        req_valid = 1'b1;
        req_op    = 3'd5;
        req_a     = 32'd100;
        req_b     = 32'd7;
        repeat (6) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        check("flush_abort", bus.core_abort, 1);
        check("flush_res_valid", res_valid, 0);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("flush_stall_after", stall_o, 0);
        check("flush_abort_1cyc", bus.core_abort, 0);
        check("flush_aborts", abort_cnt - a0, 1);
        check("flush_starts", start_cnt - s0, 1);
        @(posedge clk);
        #1;
        force_done = 1'b1;
        @(posedge clk);
        #1;
        force_done = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (res_valid || stall_o) bad++;
        end
        check("late_done_ignored", bad, 0);
        @(posedge clk);
        #1;
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, stl, ns);
        check("mulhu_res", res, 32'hFFFF_FFFE);
        check("mulhu_lat", lat, 35);

        // Reset while waiting on the core
        req_valid = 1'b1;
        req_op    = 3'd0;
        req_a     = 32'd5;
        req_b     = 32'd5;
        repeat (4) @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_stall", stall_o, 0);
        check("midrst_res_valid", res_valid, 0);
        check("midrst_start", bus.core_start, 0);
        check("midrst_abort", bus.core_abort, 0);
        check("midrst_core_a", bus.core_a, 0);
        check("midrst_core_b", bus.core_b, 0);
        check("midrst_res", res_o, 0);
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (res_valid || stall_o) bad++;
        end
        check("midrst_quiet", bad, 0);
        @(posedge clk);
        #1;

        core_lat = 3;
        do_op(3'd0, 32'd6, 32'd7, res, lat, stl, ns);
        check("mul_res", res, 42);
        check("mul_lat", lat, 6);
        do_op(3'd2, 32'hFFFF_FFFF, 32'd2, res, lat, stl, ns);
        check("mulhsu_res", res, 32'hFFFF_FFFF);
        check("mulhsu_lat", lat, 6);
        check("mulhsu_stall", stl, 6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
